// File: rtl/uart_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_sequencer_pkg
//  Description : Shared types and constants for the UART frame sequencer:
//                FSM state encoding, frame length, default header byte and
//                the frame byte selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_sequencer_pkg;

    localparam int         FRAME_LEN      = 5;
    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Byte 'idx' of a frame; index 4 (and anything above) is the XOR checksum
    // of the four preceding bytes.
    function automatic logic [7:0] frame_byte(input logic [7:0]  header,
                                              input logic [2:0]  sensor,
                                              input logic [15:0] data,
                                              input logic [2:0]  idx);
        logic [7:0] w_sensor_byte;
        w_sensor_byte = {5'b00000, sensor};
        case (idx)
            3'd0:    frame_byte = header;
            3'd1:    frame_byte = w_sensor_byte;
            3'd2:    frame_byte = data[15:8];
            3'd3:    frame_byte = data[7:0];
            default: frame_byte = header ^ w_sensor_byte ^ data[15:8] ^ data[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_sequencer_if
//  Description : Request handshake from the scheduler plus the byte-level
//                handshake to the UART transmitter. The slave modport is the
//                sequencer's view, master is the environment's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sensor;
    logic [15:0] req_data;
    logic        uart_start;
    logic [7:0]  uart_byte;
    logic        uart_done;

    modport master (
        output req_valid, req_sensor, req_data, uart_done,
        input  req_ready, uart_start, uart_byte
    );

    modport slave (
        input  req_valid, req_sensor, req_data, uart_done,
        output req_ready, uart_start, uart_byte
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : uart_watchdog
//  Description : Per-byte timeout counter. Cleared when the sequencer is
//                about to wait for a byte, counts every waiting cycle without
//                uart_done, and flags expiry on the TIMEOUT_CYCLES-th cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_watchdog #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int            C_CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TIMEOUT_CYCLES - 1);

    logic [C_CW-1:0] r_count;

    // Count waiting cycles; saturate at the last value so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Enable already excludes uart_done, so a coincident done always wins.
    assign expired = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_sequencer
//  Description : Accepts one sensor word at a time and sends it to a UART
//                transmitter as a 5-byte frame (header, sensor, data hi,
//                data lo, XOR checksum), one byte per start/done handshake,
//                with a per-byte timeout that aborts the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_sequencer
    import uart_frame_sequencer_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  wire logic                clk,
    input  wire logic                rst,
    uart_frame_sequencer_if.slave    bus,
    output logic                     frame_sent,
    output logic                     timeout_err,
    output logic                     busy
);
    localparam logic [2:0] C_LAST_IDX = 3'(FRAME_LEN - 1);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [2:0]  r_sensor;
    logic [15:0] r_data;
    logic        r_ready;
    logic        r_busy;
    logic        r_uart_start;
    logic [7:0]  r_uart_byte;
    logic        r_frame_sent;
    logic        r_timeout_err;

    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    // SEND always leads to WAIT_DONE, so SEND is the "entering WAIT_DONE" cycle.
    assign w_wd_clear  = (r_state == ST_SEND);
    assign w_wd_enable = (r_state == ST_WAIT_DONE) && !bus.uart_done;

    uart_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // Frame FSM; every output is a register loaded together with the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_sensor      <= 3'd0;
            r_data        <= 16'h0000;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_uart_start  <= 1'b0;
            r_uart_byte   <= 8'h00;
            r_frame_sent  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_uart_start <= 1'b0;
            r_frame_sent <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_sensor     <= bus.req_sensor;
                        r_data       <= bus.req_data;
                        r_idx        <= 3'd0;
                        r_uart_byte  <= frame_byte(HEADER, bus.req_sensor, bus.req_data, 3'd0);
                        r_uart_start <= 1'b1;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.uart_done) begin
                        if (r_idx == C_LAST_IDX) begin
                            r_frame_sent <= 1'b1;
                            r_ready      <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_idx        <= r_idx + 3'd1;
                            r_uart_byte  <= frame_byte(HEADER, r_sensor, r_data, r_idx + 3'd1);
                            r_uart_start <= 1'b1;
                            r_state      <= ST_SEND;
                        end
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_ready       <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.uart_start = r_uart_start;
    assign bus.uart_byte  = r_uart_byte;
    assign frame_sent     = r_frame_sent;
    assign timeout_err    = r_timeout_err;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_sequencer
//  Description : Self-checking bench for uart_frame_sequencer with a
//                transmitter responder and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_sequencer;
    localparam int         T   = 16;
    localparam logic [7:0] HDR = 8'hAA;

    logic clk = 1'b0;
    logic rst;
    logic frame_sent, timeout_err, busy;

    uart_frame_sequencer_if bus ();

    uart_frame_sequencer #(
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_sent  (frame_sent),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observation records (written only by the monitor below)
    logic [7:0] mon_q[$];
    int         start_cyc[$];
    int         fs_cyc[$];
    int         terr_cyc[$];
    logic       prev_terr = 1'b0;
    int         pend = 0;

    // Stimulus-side controls (written only by the main initial block)
    int         dly[10];   // per-byte done latency in cycles; 0 = never answer
    int         base = 0;  // mon_q index where the current scenario starts
    logic [7:0] exp_q[$];
    logic       terr_exp = 1'b0;

    // Monitor plus UART transmitter responder.
    always @(negedge clk) begin
        int k;
        if (timeout_err === 1'b1 && !prev_terr) terr_cyc.push_back(cyc);
        prev_terr = (timeout_err === 1'b1);
        if (frame_sent === 1'b1) fs_cyc.push_back(cyc);
        bus.uart_done = 1'b0;
        if (rst) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.uart_done = 1'b1;
                if (busy === 1'b1) chk("byte_stable", bus.uart_byte, mon_q[$]);
            end
        end
        if (bus.uart_start === 1'b1) begin
            mon_q.push_back(bus.uart_byte);
            start_cyc.push_back(cyc);
            k = mon_q.size() - 1 - base;
            pend = (k >= 0 && k < 10) ? dly[k] : 10;
        end
    end

    // Reference: bytes the transmitter should see for one word; returns 1 if
    // the frame completes, 0 if some byte's done arrives too late (or never).
    function automatic int model_frame(input logic [2:0] s, input logic [15:0] d,
                                       input int dl[10], input int off);
        logic [7:0] fr[5];
        fr[0] = HDR;
        fr[1] = {5'b0, s};
        fr[2] = d[15:8];
        fr[3] = d[7:0];
        fr[4] = fr[0] ^ fr[1] ^ fr[2] ^ fr[3];
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(fr[i]);
            if (dl[off + i] == 0 || dl[off + i] > T) return 0;
        end
        return 1;
    endfunction

    task automatic compare_bytes(input string tag);
        chk({tag, "_nbytes"}, mon_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (base + i < mon_q.size()) ? {24'h0, mon_q[base + i]} : 32'hDEAD, {24'h0, exp_q[i]});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
        @(negedge clk);
    endtask

    // One word through the sequencer; scrambles inputs while busy.
    task automatic run_frame(input string tag, input logic [2:0] s, input logic [15:0] d);
        int ok, acc, fs0, tr0;
        logic prior_err;
        exp_q.delete();
        base = mon_q.size();
        fs0 = fs_cyc.size();
        tr0 = terr_cyc.size();
        prior_err = terr_exp;
        ok = model_frame(s, d, dly, 0);
        if (ok == 0) terr_exp = 1'b1;
        bus.req_valid = 1'b1; bus.req_sensor = s; bus.req_data = d;
        @(negedge clk);
        acc = cyc;
        chk({tag, "_ready_low"}, bus.req_ready, 1'b0);
        while (busy === 1'b1) begin
            bus.req_valid  = 1'($urandom);
            bus.req_sensor = 3'($urandom);
            bus.req_data   = 16'($urandom);
            @(negedge clk);
            if (cyc - acc > 2000) break;
        end
        bus.req_valid = 1'b0;
        wait_idle(tag);
        compare_bytes(tag);
        chk({tag, "_latency"}, (start_cyc.size() > base) ? start_cyc[base] : -1, acc);
        chk({tag, "_frame_sent"}, fs_cyc.size() - fs0, ok);
        chk({tag, "_timeout_err"}, timeout_err, terr_exp);
        if (ok == 1 && fs_cyc.size() > fs0)
            chk({tag, "_fs_time"}, fs_cyc[fs0], start_cyc[$] + dly[4] + 1);
        if (ok == 0 && !prior_err)
            chk({tag, "_to_time"}, (terr_cyc.size() > tr0) ? terr_cyc[tr0] : -1, start_cyc[$] + T + 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < 10; i++) dly[i] = v;
    endtask

    initial begin
        int fs0, n, nst;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_sensor = 3'd0; bus.req_data = 16'h0;
        set_dly(10);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_start", bus.uart_start, 1'b0);
        chk("rst_byte", bus.uart_byte, 8'h00);
        chk("rst_frame_sent", frame_sent, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Known frame: AA 03 12 34 8F, literal expectations
        set_dly(10);
        run_frame("basic", 3'd3, 16'h1234);
        exp_q.delete();
        exp_q.push_back(8'hAA); exp_q.push_back(8'h03); exp_q.push_back(8'h12);
        exp_q.push_back(8'h34); exp_q.push_back(8'h8F);
        compare_bytes("basic_lit");

        // Done on the expiry cycle itself still counts as done
        set_dly(T);
        run_frame("coincident", 3'd5, 16'hBEEF);

        // Back-to-back words with req_valid held high; checksum AA^07^FF^FF = AD
        set_dly(10);
        exp_q.delete();
        base = mon_q.size();
        fs0 = fs_cyc.size();
        void'(model_frame(3'd0, 16'h0000, dly, 0));
        void'(model_frame(3'd7, 16'hFFFF, dly, 5));
        bus.req_valid = 1'b1; bus.req_sensor = 3'd0; bus.req_data = 16'h0000;
        @(negedge clk);
        bus.req_sensor = 3'd7; bus.req_data = 16'hFFFF;
        n = 0;
        while (mon_q.size() - base < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        wait_idle("b2b");
        compare_bytes("b2b");
        chk("b2b_frames", fs_cyc.size() - fs0, 2);
        chk("b2b_gap", (start_cyc.size() > base + 5 && fs_cyc.size() > fs0) ?
            start_cyc[base + 5] - fs_cyc[fs0] : -1, 1);
        repeat (8) @(negedge clk);

        // Done one cycle too late on byte 3: abort, late done lands in IDLE
        set_dly(10);
        dly[3] = T + 1;
        run_frame("late", 3'd2, 16'hA5C3);

        // No done after byte 1 while error is already sticky
        set_dly(10);
        dly[1] = 0;
        run_frame("never", 3'd1, 16'h0F0F);

        // Randomised words keep flowing while timeout_err stays set
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 10; i++) dly[i] = $urandom_range(1, T);
            if (r == 5) dly[$urandom_range(0, 4)] = T + 1 + $urandom_range(0, 4);
            run_frame($sformatf("rnd%0d", r), 3'($urandom), 16'($urandom));
        end

        // Reset in the middle of byte 2
        set_dly(10);
        base = mon_q.size();
        bus.req_valid = 1'b1; bus.req_sensor = 3'd6; bus.req_data = 16'hC0DE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (mon_q.size() - base < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_start", bus.uart_start, 1'b0);
        chk("midrst_ready", bus.req_ready, 1'b1);
        chk("midrst_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        terr_exp = 1'b0;
        nst = mon_q.size();
        repeat (30) @(negedge clk);
        chk("midrst_no_start", mon_q.size(), nst);
        run_frame("after_rst", 3'd6, 16'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
